// File: rtl/led_mode_ctrl.sv
// LED mode controller: debounced keys drive run/pause, pattern mode and speed.
// Emits a registered step index and a one-cycle tick on each step advance.
module led_mode_ctrl #(
    parameter logic [19:0] DEB_CNT  = 20'd999_999,
    parameter logic [23:0] TICK_DEF = 24'd9_999_999,
    parameter logic [23:0] TICK_MIN = 24'd1_249_999,
    parameter logic [23:0] TICK_MAX = 24'd15_999_999
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [3:0] key,
    output logic       led_en,
    output logic       running,
    output logic [1:0] mode,
    output logic [1:0] step,
    output logic       tick
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [3:0]       deb;
    logic [3:0]       deb_d;
    logic [3:0]       press;
    logic [3:0][19:0] dcnt;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  mode_nxt;
    logic [1:0]  step_nxt;
    logic [23:0] per;
    logic [23:0] per_nxt;
    logic [23:0] cnt;
    logic [23:0] cnt_nxt;
    logic        tick_nxt;
    logic [23:0] per_half;
    logic [24:0] per_dbl;

    assign per_half = per >> 1;
    assign per_dbl  = {per, 1'b1};

    // Two-flop synchronizer; idles high like a released key
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
        end
    end

    // Per-key debounce: level follows only after a full stable run
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            deb  <= '1;
            dcnt <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == deb[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == DEB_CNT) begin
                    deb[i]  <= sync2[i];
                    dcnt[i] <= '0;
                end else begin
                    dcnt[i] <= dcnt[i] + 20'd1;
                end
            end
        end
    end

    // Registered press pulse on a debounced 1->0 transition
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            deb_d <= '1;
            press <= '0;
        end else begin
            deb_d <= deb;
            press <= deb_d & ~deb;
        end
    end

    // Controller state register
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and datapath; lowest key wins, key beats a due tick
    always_comb begin
        state_nxt = state;
        mode_nxt  = mode;
        step_nxt  = step;
        per_nxt   = per;
        cnt_nxt   = cnt;
        tick_nxt  = 1'b0;
        if (press[0]) begin
            mode_nxt = mode + 2'd1;
            step_nxt = 2'd0;
            cnt_nxt  = '0;
        end else if (press[1]) begin
            unique case (state)
                IDLE:    state_nxt = RUN;
                RUN:     state_nxt = PAUSE;
                PAUSE:   state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end else if (press[2]) begin
            if (per_half < TICK_MIN) begin
                per_nxt = TICK_MIN;
            end else begin
                per_nxt = per_half;
            end
            cnt_nxt = '0;
        end else if (press[3]) begin
            if (per_dbl > {1'b0, TICK_MAX}) begin
                per_nxt = TICK_MAX;
            end else begin
                per_nxt = per_dbl[23:0];
            end
            cnt_nxt = '0;
        end else if (state == RUN) begin
            if (cnt == per) begin
                tick_nxt = 1'b1;
                cnt_nxt  = '0;
                step_nxt = step + 2'd1;
            end else begin
                cnt_nxt = cnt + 24'd1;
            end
        end else if (state == IDLE) begin
            cnt_nxt = '0;
        end
    end

    // Registered datapath and outputs
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            mode    <= 2'd0;
            step    <= 2'd0;
            per     <= TICK_DEF;
            cnt     <= '0;
            tick    <= 1'b0;
            led_en  <= 1'b0;
            running <= 1'b0;
        end else begin
            mode    <= mode_nxt;
            step    <= step_nxt;
            per     <= per_nxt;
            cnt     <= cnt_nxt;
            tick    <= tick_nxt;
            led_en  <= (state_nxt != IDLE);
            running <= (state_nxt == RUN);
        end
    end

endmodule
